// File: rtl/tx_cc_framer_pkg.sv
// Definitions shared by the tx and rx clock-compensation paths: K-code characters,
// the |S| fill word, the RS word-counter width and the framer state encoding.
package tx_cc_framer_pkg;

   localparam logic [7:0]  CHAR_I   = 8'hBC;   // K28.5
   localparam logic [7:0]  CHAR_S   = 8'hFB;   // K27.7
   localparam logic [7:0]  CHAR_A   = 8'h7C;   // K28.3
   localparam logic [31:0] SOF_FILL = 32'h5555_5555;

   localparam int unsigned RS_CNT_W = 10;

   typedef enum logic [0:0] {
      StIdle,
      StBlock
   } framer_state_e;

   function automatic logic [31:0] all_lanes(input logic [7:0] ch);
      return {4{ch}};
   endfunction

endpackage

// File: rtl/tx_align_timer.sv
// Free-running alignment timer: counts output cycles and flags the cycle in which
// an |A| character must replace normal traffic.
module tx_align_timer #(
   parameter int unsigned ALIGN_PERIOD = 1024
) (
   input  logic i_unif_clk,
   input  logic r_u_unif_rst_n,
   input  logic align_en,
   output logic align_due,
   output logic align_due_next
);

   localparam int unsigned CNT_W = $clog2(ALIGN_PERIOD);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALIGN_PERIOD - 1);
   localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(ALIGN_PERIOD - 2);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             due_q, due_d;

   // Counter is parked at zero whenever alignment is disabled.
   always_comb begin
      cnt_d = '0;
      due_d = 1'b0;
      if (align_en) begin
         cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
         due_d = (cnt_q == CNT_PRE);
      end
   end

   always_ff @(posedge i_unif_clk or negedge r_u_unif_rst_n) begin
      if (!r_u_unif_rst_n) begin
         cnt_q <= '0;
         due_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         due_q <= due_d;
      end
   end

   assign align_due      = due_q;
   assign align_due_next = due_d;

endmodule

// File: rtl/tx_cc_framer.sv
// Transmit framer: replaces word 0 of each RS block with |S|, fills gaps with |I|
// and periodically inserts |A| for clock compensation. All outputs registered.
module tx_cc_framer
   import tx_cc_framer_pkg::*;
#(
   parameter int unsigned RS_N         = 255,
   parameter int unsigned RS_K         = 223,
   parameter int unsigned ALIGN_PERIOD = 1024
) (
   input  logic        i_unif_clk,
   input  logic        r_u_unif_rst_n,
   input  logic [31:0] i_u_data,
   input  logic        i_u_sof,
   input  logic        i_u_valid,
   output logic        o_u_ready,
   input  logic        i_r_align_en,
   output logic [31:0] o_u_data,
   output logic [3:0]  o_u_datak,
   output logic        o_u_rs_data_symbol,
   output logic        o_u_rs_check_symbol,
   output logic        o_u_sof_err
);

   localparam logic [RS_CNT_W-1:0] LAST_WORD  = RS_CNT_W'(RS_N - 1);
   localparam logic [RS_CNT_W-1:0] FIRST_CHK  = RS_CNT_W'(RS_K);

   framer_state_e       state_q, state_d;
   logic [RS_CNT_W-1:0] word_cnt_q, word_cnt_d;
   logic [31:0]         data_q, data_d;
   logic [3:0]          datak_q, datak_d;
   logic                rs_data_q, rs_data_d;
   logic                rs_check_q, rs_check_d;
   logic                sof_err_q, sof_err_d;
   logic                ready_q;
   logic                align_due, align_due_next;
   logic                xfer;

   tx_align_timer #(
      .ALIGN_PERIOD (ALIGN_PERIOD)
   ) u_align_timer (
      .i_unif_clk     (i_unif_clk),
      .r_u_unif_rst_n (r_u_unif_rst_n),
      .align_en       (i_r_align_en),
      .align_due      (align_due),
      .align_due_next (align_due_next)
   );

   assign xfer = i_u_valid && ready_q;

   always_comb begin
      state_d    = state_q;
      word_cnt_d = word_cnt_q;
      data_d     = all_lanes(CHAR_I);
      datak_d    = 4'hF;
      rs_data_d  = 1'b0;
      rs_check_d = 1'b0;
      sof_err_d  = 1'b0;

      // ready is low whenever align_due is set, so |A| never competes with a transfer.
      if (align_due) begin
         data_d = all_lanes(CHAR_A);
      end else if (xfer) begin
         if (i_u_sof) begin
            data_d     = all_lanes(CHAR_S);
            rs_data_d  = 1'b1;
            word_cnt_d = RS_CNT_W'(1);
            sof_err_d  = (state_q == StBlock);
            state_d    = StBlock;
         end else if (state_q == StIdle) begin
            sof_err_d = 1'b1;
         end else begin
            data_d     = i_u_data;
            datak_d    = 4'h0;
            rs_data_d  = (word_cnt_q < FIRST_CHK);
            rs_check_d = (word_cnt_q >= FIRST_CHK);
            if (word_cnt_q == LAST_WORD) begin
               word_cnt_d = '0;
               state_d    = StIdle;
            end else begin
               word_cnt_d = word_cnt_q + RS_CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge i_unif_clk or negedge r_u_unif_rst_n) begin
      if (!r_u_unif_rst_n) begin
         state_q    <= StIdle;
         word_cnt_q <= '0;
         data_q     <= all_lanes(CHAR_I);
         datak_q    <= 4'hF;
         rs_data_q  <= 1'b0;
         rs_check_q <= 1'b0;
         sof_err_q  <= 1'b0;
         ready_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         word_cnt_q <= word_cnt_d;
         data_q     <= data_d;
         datak_q    <= datak_d;
         rs_data_q  <= rs_data_d;
         rs_check_q <= rs_check_d;
         sof_err_q  <= sof_err_d;
         ready_q    <= !align_due_next;
      end
   end

   assign o_u_ready           = ready_q;
   assign o_u_data            = data_q;
   assign o_u_datak           = datak_q;
   assign o_u_rs_data_symbol  = rs_data_q;
   assign o_u_rs_check_symbol = rs_check_q;
   assign o_u_sof_err         = sof_err_q;

endmodule
